exp4_unidade_controle: RTL and testbench
========================================

EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

Interface
REQ-001 Parameter TIMEOUT, default 5000, is the number of idle cycles allowed in ESPERA before a timeout.
REQ-002 Port clock, input, 1, is the single system clock; all state changes occur on its rising edge.
REQ-003 Port reset, input, 1, is an asynchronous, active-low reset.
REQ-004 Port iniciar, input, 1, is the start/restart request (level sampled on the clock).
REQ-005 Port jogada_feita, input, 1, is the one-cycle play pulse from the datapath edge detector.
REQ-006 Port igual, input, 1, is 1 when the registered play equals the ROM word.
REQ-007 Port fimC, input, 1, is the address-counter terminal count (address 15).
REQ-008 Port zeraC, output, 1, clears the address counter and edge detector.
REQ-009 Port contaC, output, 1, increments the address counter.
REQ-010 Port zeraR, output, 1, clears the play register.
REQ-011 Port registraR, output, 1, loads the play register.
REQ-012 Port pronto, output, 1, signals that the round has ended.
REQ-013 Port acertou, output, 1, signals that all 16 plays matched.
REQ-014 Port errou, output, 1, signals a mismatch.
REQ-015 Port timeout, output, 1, signals no play within TIMEOUT cycles.
REQ-016 Port db_estado, output, 4, is the current-state code for debug.

Function
REQ-017 The FSM SHALL be Moore; all outputs SHALL be a function of the state register only.
REQ-018 State codes SHALL be: INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTOU=A, FIM_TIMEOUT=D, FIM_ERROU=E.
REQ-019 INICIAL SHALL go to PREPARACAO if iniciar=1, else hold; all outputs 0.
REQ-020 PREPARACAO SHALL assert zeraC=1 and zeraR=1 for exactly one cycle, then go to ESPERA.
REQ-021 ESPERA SHALL go to REGISTRA on jogada_feita=1.
REQ-022 ESPERA SHALL go to FIM_TIMEOUT when the idle counter equals TIMEOUT-1 and jogada_feita=0.
REQ-023 If jogada_feita=1 and the timeout condition hold in the same cycle, the play SHALL win and the FSM SHALL go to REGISTRA.
REQ-024 REGISTRA SHALL assert registraR=1 for one cycle, then go to COMPARACAO.
REQ-025 COMPARACAO SHALL go to FIM_ERROU if igual=0, to FIM_ACERTOU if igual=1 and fimC=1, and to PROXIMO otherwise.
REQ-026 PROXIMO SHALL assert contaC=1 for one cycle, then go to ESPERA; the ROM word is valid before the next COMPARACAO.
REQ-027 FIM_* states SHALL assert pronto=1 plus exactly one of acertou, timeout or errou.
REQ-028 FIM_* states SHALL hold until iniciar=1, then go to PREPARACAO (restart without reset).
REQ-029 The idle counter SHALL be $clog2(TIMEOUT) bits, SHALL clear on entry to ESPERA, SHALL increment each cycle in ESPERA, and SHALL never wrap.
REQ-030 A full round without error SHALL produce exactly 15 contaC pulses and 16 registraR pulses.
REQ-031 An iniciar input held high during play SHALL be ignored outside INICIAL and FIM_*.

Reset
REQ-032 reset=0 SHALL immediately force INICIAL, clear the idle counter, and drive all outputs to 0 (db_estado=0), including mid-round.
REQ-033 After reset is released, the first transition SHALL occur on the first rising clock edge with iniciar=1.

Structure
REQ-034 State codes and the TIMEOUT default SHALL live in shared package exp4_pkg.
REQ-035 The idle counter SHALL be one sub-module, contador_timeout (clear, enable, terminal-count output).
REQ-036 The controller SHALL contain no datapath registers other than the state and idle counter.

Verification
REQ-037 Reset pulse mid-ESPERA -> db_estado=0 immediately and all outputs 0 while reset=0.
REQ-038 iniciar, then 16 plays with igual=1 and fimC=1 on the 16th -> FIM_ACERTOU (db_estado=A), pronto=1, 15 contaC pulses.
REQ-039 iniciar, then play 3 with igual=0 -> FIM_ERROU (E), errou=1, 2 contaC pulses.
REQ-040 TIMEOUT=8 and no play -> FIM_TIMEOUT (D) exactly 8 cycles after entering ESPERA, with timeout=1.
REQ-041 TIMEOUT=8 with jogada_feita in the 8th ESPERA cycle -> REGISTRA, not FIM_TIMEOUT.
REQ-042 From FIM_ERROU, iniciar=1 -> PREPARACAO with zeraC=1 and zeraR=1 for one cycle, then ESPERA.

Source files
------------

// File: rtl/exp4_pkg.sv
// Shared definitions for the memory-game control unit: state codes,
// the default idle limit and the Moore output decode.
package exp4_pkg;

  localparam int TIMEOUT_DEFAULT = 5000;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Every output is fixed by the state alone.
  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zeraC = 1'b1;
        s.zeraR = 1'b1;
      end
      REGISTRA:   s.registraR = 1'b1;
      PROXIMO:    s.contaC    = 1'b1;
      FIM_ACERTOU: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exp4_unidade_controle_if.sv
// Handshake between the control unit (slave side) and the datapath that
// feeds it status and consumes its control strobes (master side).
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada_feita;
  logic       igual;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada_feita, igual, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada_feita, igual, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle_contador_timeout.sv
// Idle-cycle counter for the wait state: saturates at TIMEOUT-1 and flags
// that value as its terminal count.
module contador_timeout #(
  parameter int TIMEOUT = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam int            W      = $clog2(TIMEOUT);
  localparam logic [W-1:0]  ULTIMO = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Holding at the terminal value keeps the counter from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (zera_i)
      cnt_d = '0;
    else if (conta_i && (cnt_q != ULTIMO))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign fim_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the 16-play memory round: waits for each play,
// compares it, advances the address and reports hit, miss or idle timeout.
module exp4_unidade_controle
  import exp4_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  exp4_unidade_controle_if.slave   ctrl
);

  estado_t state_q;
  estado_t state_d;
  saidas_t saidas_q;
  logic    fim_timeout;

  // The idle counter is held clear outside the wait state, so it restarts
  // from zero on every entry into it.
  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_timeout (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (state_q != ESPERA),
    .conta_i (state_q == ESPERA),
    .fim_o   (fim_timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    if (ctrl.iniciar) state_d = PREPARACAO;
      PREPARACAO: state_d = ESPERA;
      // A play arriving on the last idle cycle takes priority over timeout.
      ESPERA: begin
        if (ctrl.jogada_feita)
          state_d = REGISTRA;
        else if (fim_timeout)
          state_d = FIM_TIMEOUT;
      end
      REGISTRA:   state_d = COMPARACAO;
      COMPARACAO: begin
        if (!ctrl.igual)
          state_d = FIM_ERROU;
        else if (ctrl.fimC)
          state_d = FIM_ACERTOU;
        else
          state_d = PROXIMO;
      end
      PROXIMO:    state_d = ESPERA;
      FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
        if (ctrl.iniciar) state_d = PREPARACAO;
      default:    state_d = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= INICIAL;
      saidas_q <= '0;
    end else begin
      state_q  <= state_d;
      saidas_q <= decodifica(state_d);
    end
  end

  assign ctrl.zeraC     = saidas_q.zeraC;
  assign ctrl.contaC    = saidas_q.contaC;
  assign ctrl.zeraR     = saidas_q.zeraR;
  assign ctrl.registraR = saidas_q.registraR;
  assign ctrl.pronto    = saidas_q.pronto;
  assign ctrl.acertou   = saidas_q.acertou;
  assign ctrl.errou     = saidas_q.errou;
  assign ctrl.timeout   = saidas_q.timeout;
  assign ctrl.db_estado = state_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle with TIMEOUT=8.
module tb_exp4_unidade_controle;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   n_conta;
  int   n_reg;

  exp4_unidade_controle_if cif ();

  exp4_unidade_controle #(
    .TIMEOUT (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (cif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cif.contaC === 1'b1)    n_conta++;
    if (cif.registraR === 1'b1) n_reg++;
  end

  // {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [11:0] obs();
    return {cif.db_estado, cif.zeraC, cif.contaC, cif.zeraR, cif.registraR,
            cif.pronto, cif.acertou, cif.errou, cif.timeout};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One play starting from ESPERA; ends in ESPERA after a hit, else in a FIM state.
  task automatic play(input logic ig, input logic fc);
    cif.jogada_feita = 1'b1;
    step();
    cif.jogada_feita = 1'b0;
    step();
    cif.igual = ig;
    cif.fimC  = fc;
    step();
    cif.igual = 1'b0;
    cif.fimC  = 1'b0;
    if (ig && !fc) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cif.iniciar = 1'b0; cif.jogada_feita = 1'b0; cif.igual = 1'b0; cif.fimC = 1'b0;
    step(); step();
    checks++; if (obs() !== 12'h000) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs(), 12'h000); end
    reset = 1'b1;
    step(); step(); step();
    checks++; if (obs() !== 12'h000) begin failures++; $display("FAIL idle_hold got=%h exp=%h", obs(), 12'h000); end
    cif.iniciar = 1'b1;
    step();
    checks++; if (obs() !== 12'h1A0) begin failures++; $display("FAIL first_start got=%h exp=%h", obs(), 12'h1A0); end
    cif.iniciar = 1'b0;
    step();
    checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL enter_espera got=%h exp=%h", obs(), 12'h200); end
  endtask

  task automatic test_errou();
    n_conta = 0;
    cif.jogada_feita = 1'b1;
    step();
    cif.jogada_feita = 1'b0;
    checks++; if (obs() !== 12'h410) begin failures++; $display("FAIL registra got=%h exp=%h", obs(), 12'h410); end
    step();
    checks++; if (obs() !== 12'h500) begin failures++; $display("FAIL comparacao got=%h exp=%h", obs(), 12'h500); end
    cif.igual = 1'b1;
    step();
    cif.igual = 1'b0;
    checks++; if (obs() !== 12'h640) begin failures++; $display("FAIL proximo got=%h exp=%h", obs(), 12'h640); end
    step();
    checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL back_espera got=%h exp=%h", obs(), 12'h200); end
    play(1'b1, 1'b0);
    play(1'b0, 1'b0);
    checks++; if (obs() !== 12'hE0A) begin failures++; $display("FAIL fim_errou got=%h exp=%h", obs(), 12'hE0A); end
    checks++; if (n_conta !== 2) begin failures++; $display("FAIL errou_contaC got=%0d exp=%0d", n_conta, 2); end
    step();
    checks++; if (obs() !== 12'hE0A) begin failures++; $display("FAIL errou_hold got=%h exp=%h", obs(), 12'hE0A); end
  endtask

  task automatic test_restart();
    cif.iniciar = 1'b1;
    step();
    cif.iniciar = 1'b0;
    checks++; if (obs() !== 12'h1A0) begin failures++; $display("FAIL restart_prep got=%h exp=%h", obs(), 12'h1A0); end
    step();
    checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL restart_espera got=%h exp=%h", obs(), 12'h200); end
  endtask

  task automatic test_timeout();
    for (int i = 2; i <= 8; i++) begin
      step();
      checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL timeout_wait%0d got=%h exp=%h", i, obs(), 12'h200); end
    end
    step();
    checks++; if (obs() !== 12'hD09) begin failures++; $display("FAIL fim_timeout got=%h exp=%h", obs(), 12'hD09); end
  endtask

  task automatic test_tie();
    cif.iniciar = 1'b1;
    step();
    cif.iniciar = 1'b0;
    step();
    for (int i = 2; i <= 8; i++) step();
    checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL tie_cycle8 got=%h exp=%h", obs(), 12'h200); end
    cif.jogada_feita = 1'b1;
    step();
    cif.jogada_feita = 1'b0;
    checks++; if (obs() !== 12'h410) begin failures++; $display("FAIL tie_registra got=%h exp=%h", obs(), 12'h410); end
    step();
    step();
    checks++; if (obs() !== 12'hE0A) begin failures++; $display("FAIL tie_errou got=%h exp=%h", obs(), 12'hE0A); end
  endtask

  task automatic test_acertou();
    cif.iniciar = 1'b1;
    step();
    step();
    n_conta = 0;
    n_reg   = 0;
    for (int i = 0; i < 15; i++) begin
      play(1'b1, 1'b0);
      if (i == 7) begin
        checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL acertou_mid got=%h exp=%h", obs(), 12'h200); end
      end
    end
    play(1'b1, 1'b1);
    checks++; if (obs() !== 12'hA0C) begin failures++; $display("FAIL fim_acertou got=%h exp=%h", obs(), 12'hA0C); end
    checks++; if (n_conta !== 15) begin failures++; $display("FAIL acertou_contaC got=%0d exp=%0d", n_conta, 15); end
    checks++; if (n_reg !== 16) begin failures++; $display("FAIL acertou_registraR got=%0d exp=%0d", n_reg, 16); end
    cif.iniciar = 1'b0;
    step();
    checks++; if (obs() !== 12'hA0C) begin failures++; $display("FAIL acertou_hold got=%h exp=%h", obs(), 12'hA0C); end
  endtask

  task automatic test_reset_mid();
    cif.iniciar = 1'b1;
    step();
    step();
    step(); step(); step();
    checks++; if (obs() !== 12'h200) begin failures++; $display("FAIL mid_espera got=%h exp=%h", obs(), 12'h200); end
    reset = 1'b0;
    #1;
    checks++; if (obs() !== 12'h000) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(), 12'h000); end
    step(); step();
    checks++; if (obs() !== 12'h000) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs(), 12'h000); end
    cif.iniciar = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++; if (obs() !== 12'h000) begin failures++; $display("FAIL post_reset_idle got=%h exp=%h", obs(), 12'h000); end
    cif.iniciar = 1'b1;
    step();
    cif.iniciar = 1'b0;
    checks++; if (obs() !== 12'h1A0) begin failures++; $display("FAIL post_reset_start got=%h exp=%h", obs(), 12'h1A0); end
    step();
    for (int i = 2; i <= 9; i++) step();
    checks++; if (obs() !== 12'hD09) begin failures++; $display("FAIL post_reset_timeout got=%h exp=%h", obs(), 12'hD09); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_conta  = 0;
    n_reg    = 0;
    test_reset();
    test_errou();
    test_restart();
    test_timeout();
    test_tie();
    test_acertou();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
